alu_operand_collector: RTL and testbench

Parametrised operand-pairing front end placed between the stimulus/bus side and the ALU core. It accepts operands that may arrive on separate cycles (INP_VALID bit 0 = OPA, bit 1 = OPB) and decodes which operands each MODE/CMD needs. It enforces a programmable wait timeout and presents one complete, registered operation to the ALU over a valid/ready handshake, flagging missing-operand and invalid-valid errors in-band.

---
 rtl/alu_operand_collector.sv | 172 +++++++++++++++++
 tb/tb_alu_operand_collector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_collector.sv
// Operand-pairing front end for the ALU: collects OPA/OPB that may arrive on
// different cycles, bounds the wait with a timeout, and holds one operation for a valid/ready hand-off.
module alu_operand_collector #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 CE,
  input  logic [1:0]           INP_VALID,
  input  logic                 MODE,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [OP_WIDTH-1:0]  OPA,
  input  logic [OP_WIDTH-1:0]  OPB,
  input  logic                 CIN,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [CMD_WIDTH-1:0] out_cmd,
  output logic                 out_cin,
  output logic [OP_WIDTH-1:0]  out_opa,
  output logic [OP_WIDTH-1:0]  out_opb,
  output logic                 out_err,
  output logic [1:0]           dbg_state
);

  // Handshake: out_valid rises only in HOLD and stays up with out_* stable
  // until out_valid && out_ready is seen on a CE=1 edge; in_ready is low
  // exactly while an operation is held.

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_A = 2'd1,
    S_WAIT_B = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mode_q, mode_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  cin_q, cin_d;
  logic [OP_WIDTH-1:0]   opa_q, opa_d;
  logic [OP_WIDTH-1:0]   opb_q, opb_d;
  logic                  err_q, err_d;
  logic [1:0]            need;
  logic [TW-1:0]         timer_inc;

  // Returns {need_b, need_a}; unknown codes default to needing both.
  function automatic logic [1:0] decode_need(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    logic [1:0] n;
    n = 2'b11;
    if (mode) begin
      if (cmd == CMD_WIDTH'(4) || cmd == CMD_WIDTH'(5)) n = 2'b01;
      else if (cmd == CMD_WIDTH'(6) || cmd == CMD_WIDTH'(7)) n = 2'b10;
    end else begin
      if (cmd == CMD_WIDTH'(6) || cmd == CMD_WIDTH'(8) || cmd == CMD_WIDTH'(9)) n = 2'b01;
      else if (cmd == CMD_WIDTH'(7) || cmd == CMD_WIDTH'(10) || cmd == CMD_WIDTH'(11)) n = 2'b10;
    end
    return n;
  endfunction

  assign need      = decode_need(MODE, CMD);
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    cin_d   = cin_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    err_d   = err_q;
    if (CE) begin
      unique case (state_q)
        S_IDLE: begin
          mode_d  = MODE;
          cmd_d   = CMD;
          cin_d   = CIN;
          timer_d = '0;
          err_d   = 1'b0;
          opa_d   = (need[0] && INP_VALID[0]) ? OPA : '0;
          opb_d   = (need[1] && INP_VALID[1]) ? OPB : '0;
          if (INP_VALID == 2'b00) begin
            err_d   = 1'b1;
            state_d = S_HOLD;
          end else if ((need & ~INP_VALID) == 2'b00) begin
            state_d = S_HOLD;
          end else if (need[1] && !INP_VALID[1]) begin
            state_d = S_WAIT_B;
          end else begin
            state_d = S_WAIT_A;
          end
        end
        S_WAIT_A: begin
          if (INP_VALID[0]) begin
            opa_d   = OPA;
            timer_d = '0;
            state_d = S_HOLD;
          end else if (timer_inc == TIMEOUT_T) begin
            opa_d   = '0;
            err_d   = 1'b1;
            timer_d = '0;
            state_d = S_HOLD;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_WAIT_B: begin
          if (INP_VALID[1]) begin
            opb_d   = OPB;
            timer_d = '0;
            state_d = S_HOLD;
          end else if (timer_inc == TIMEOUT_T) begin
            opb_d   = '0;
            err_d   = 1'b1;
            timer_d = '0;
            state_d = S_HOLD;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            timer_d = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      cin_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      cin_q   <= cin_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign out_mode  = mode_q;
  assign out_cmd   = cmd_q;
  assign out_cin   = cin_q;
  assign out_opa   = opa_q;
  assign out_opb   = opb_q;
  assign out_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: one task per scenario with inline checks.
module tb_alu_operand_collector;

  logic       clk;
  logic       RST;
  logic       CE;
  logic [1:0] INP_VALID;
  logic       MODE;
  logic [3:0] CMD;
  logic [7:0] OPA;
  logic [7:0] OPB;
  logic       CIN;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_mode;
  logic [3:0] out_cmd;
  logic       out_cin;
  logic [7:0] out_opa;
  logic [7:0] out_opb;
  logic       out_err;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  alu_operand_collector #(.OP_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE), .CMD(CMD),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_mode(out_mode), .out_cmd(out_cmd), .out_cin(out_cin),
    .out_opa(out_opa), .out_opb(out_opb), .out_err(out_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are settled and inputs can be changed at #1 after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic m, input logic [3:0] c, input logic [1:0] iv,
                          input logic [7:0] a, input logic [7:0] b, input logic ci);
    CE = 1'b1; MODE = m; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
  endtask

  task automatic consume();
    CE = 1'b1; out_ready = 1'b1; INP_VALID = 2'b11;
    cyc();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL consume_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL consume_in_ready got=%b exp=1", in_ready); errors++; end
    out_ready = 1'b0; CE = 1'b0; INP_VALID = 2'b00;
  endtask

  task automatic test_reset();
    RST = 1'b0; CE = 1'b0; INP_VALID = 2'b00; MODE = 1'b0; CMD = 4'd0;
    OPA = 8'h00; OPB = 8'h00; CIN = 1'b0; out_ready = 1'b0;
    repeat (2) cyc();
    RST = 1'b1;
    drive_op(1'b1, 4'd0, 2'b01, 8'h77, 8'h00, 1'b1);
    cyc();
    checks++; if (dbg_state !== 2'd2) begin $display("FAIL rst_pre_wait state got=%0d exp=2", dbg_state); errors++; end
    RST = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rst_ctrl valid=%b err=%b in_ready=%b exp=0/0/1", out_valid, out_err, in_ready); errors++; end
    checks++; if ({out_mode, out_cmd, out_cin, out_opa, out_opb} !== 22'd0) begin
      $display("FAIL rst_data got=%h exp=0", {out_mode, out_cmd, out_cin, out_opa, out_opb}); errors++; end
    checks++; if (dbg_state !== 2'd0) begin $display("FAIL rst_state got=%0d exp=0", dbg_state); errors++; end
    cyc();
    RST = 1'b1;
    drive_op(1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin
      $display("FAIL first_op valid=%b err=%b exp=1/0", out_valid, out_err); errors++; end
    checks++; if (out_opa !== 8'h12 || out_opb !== 8'h34 || out_mode !== 1'b1 || out_cmd !== 4'd0) begin
      $display("FAIL first_op_data opa=%h opb=%h mode=%b cmd=%0d exp=12/34/1/0", out_opa, out_opb, out_mode, out_cmd); errors++; end
    consume();
  endtask

  task automatic test_split();
    drive_op(1'b1, 4'd0, 2'b01, 8'hAA, 8'h00, 1'b0);
    cyc();
    checks++; if (dbg_state !== 2'd2 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL split_wait state=%0d valid=%b in_ready=%b exp=2/0/1", dbg_state, out_valid, in_ready); errors++; end
    for (int i = 0; i < 4; i++) begin
      INP_VALID = (i == 1) ? 2'b01 : 2'b00;
      OPA = 8'hFF;
      cyc();
      checks++; if (out_valid !== 1'b0) begin $display("FAIL split_idle%0d valid=%b exp=0", i, out_valid); errors++; end
    end
    INP_VALID = 2'b10; OPB = 8'h55;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_opa !== 8'hAA || out_opb !== 8'h55) begin
      $display("FAIL split_done valid=%b err=%b opa=%h opb=%h exp=1/0/aa/55", out_valid, out_err, out_opa, out_opb); errors++; end
    consume();
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 4'd0, 2'b01, 8'h3C, 8'h00, 1'b0);
    cyc();
    INP_VALID = 2'b00; OPB = 8'hEE;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i < 16) begin
        checks++; if (out_valid !== 1'b0) begin $display("FAIL timeout_early%0d valid=%b exp=0", i, out_valid); errors++; end
      end else begin
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_opb !== 8'h00 || out_opa !== 8'h3C) begin
          $display("FAIL timeout_hit valid=%b err=%b opa=%h opb=%h exp=1/1/3c/00", out_valid, out_err, out_opa, out_opb); errors++; end
      end
    end
    consume();
    drive_op(1'b1, 4'd0, 2'b01, 8'h3C, 8'h00, 1'b0);
    cyc();
    INP_VALID = 2'b00;
    repeat (15) cyc();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL timeout_edge_pre valid=%b exp=0", out_valid); errors++; end
    INP_VALID = 2'b10; OPB = 8'h99;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_opb !== 8'h99) begin
      $display("FAIL timeout_edge_arrive valid=%b err=%b opb=%h exp=1/0/99", out_valid, out_err, out_opb); errors++; end
    consume();
  endtask

  task automatic test_decode();
    drive_op(1'b0, 4'd8, 2'b01, 8'h0F, 8'hEE, 1'b0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_opa !== 8'h0F || out_opb !== 8'h00 || out_mode !== 1'b0 || out_cmd !== 4'd8) begin
      $display("FAIL decode_log8 valid=%b err=%b opa=%h opb=%h mode=%b cmd=%0d exp=1/0/0f/00/0/8", out_valid, out_err, out_opa, out_opb, out_mode, out_cmd); errors++; end
    consume();
    drive_op(1'b1, 4'd6, 2'b01, 8'h11, 8'h00, 1'b0);
    cyc();
    checks++; if (dbg_state !== 2'd2 || out_valid !== 1'b0) begin
      $display("FAIL decode_arith6 state=%0d valid=%b exp=2/0", dbg_state, out_valid); errors++; end
    INP_VALID = 2'b10; OPB = 8'h22;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_opa !== 8'h00 || out_opb !== 8'h22) begin
      $display("FAIL decode_arith6_done valid=%b opa=%h opb=%h exp=1/00/22", out_valid, out_opa, out_opb); errors++; end
    consume();
    drive_op(1'b0, 4'd10, 2'b11, 8'h5A, 8'h6B, 1'b0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_opa !== 8'h00 || out_opb !== 8'h6B) begin
      $display("FAIL decode_log10 valid=%b opa=%h opb=%h exp=1/00/6b", out_valid, out_opa, out_opb); errors++; end
    consume();
  endtask

  task automatic test_backpressure();
    drive_op(1'b1, 4'd1, 2'b11, 8'h5A, 8'hA5, 1'b1);
    cyc();
    out_ready = 1'b0;
    drive_op(1'b0, 4'd2, 2'b11, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_opa !== 8'h5A || out_opb !== 8'hA5 || out_cin !== 1'b1 || out_cmd !== 4'd1) begin
        $display("FAIL bp_hold%0d valid=%b in_ready=%b opa=%h opb=%h cin=%b cmd=%0d exp=1/0/5a/a5/1/1", i, out_valid, in_ready, out_opa, out_opb, out_cin, out_cmd); errors++; end
    end
    CE = 1'b0; out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b1) begin $display("FAIL bp_ce0 valid=%b exp=1", out_valid); errors++; end
    CE = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_consume valid=%b in_ready=%b exp=0/1", out_valid, in_ready); errors++; end
    out_ready = 1'b0;
    drive_op(1'b1, 4'd2, 2'b11, 8'h01, 8'h02, 1'b0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_opa !== 8'h01 || out_opb !== 8'h02 || out_cmd !== 4'd2) begin
      $display("FAIL back_to_back valid=%b opa=%h opb=%h cmd=%0d exp=1/01/02/2", out_valid, out_opa, out_opb, out_cmd); errors++; end
    consume();
  endtask

  task automatic test_invalid_and_reset_wait();
    drive_op(1'b1, 4'd0, 2'b00, 8'h12, 8'h34, 1'b0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_opa !== 8'h00 || out_opb !== 8'h00) begin
      $display("FAIL invalid00 valid=%b err=%b opa=%h opb=%h exp=1/1/00/00", out_valid, out_err, out_opa, out_opb); errors++; end
    consume();
    drive_op(1'b1, 4'd0, 2'b01, 8'h44, 8'h00, 1'b0);
    cyc();
    checks++; if (dbg_state !== 2'd2) begin $display("FAIL rstwait_pre state=%0d exp=2", dbg_state); errors++; end
    RST = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0 || out_opa !== 8'h00) begin
      $display("FAIL rstwait_now valid=%b state=%0d opa=%h exp=0/0/00", out_valid, dbg_state, out_opa); errors++; end
    cyc();
    RST = 1'b1; CE = 1'b0; INP_VALID = 2'b10; OPB = 8'h55;
    repeat (3) cyc();
    checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL rstwait_lost valid=%b state=%0d exp=0/0", out_valid, dbg_state); errors++; end
  endtask

  initial begin
    test_reset();
    test_split();
    test_timeout();
    test_decode();
    test_backpressure();
    test_invalid_and_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
